// File: rtl/sbox_scheduler.sv
// Shares one 32-bit AES S-box lane between a 4-beat state job and single-word key requests.
// Define SBOX_SCHED_CNT_EN to add the stall_cnt output (RUN cycles lost to key grants).
module sbox_scheduler #(
  parameter int PRIO_KEY    = 1,
  parameter int MAX_KEY_RUN = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         kw_valid,
  output logic         kw_ready,
  input  logic [31:0]  kw_in,
  output logic [31:0]  kw_out,
  output logic         kw_done,
  output logic         busy
`ifdef SBOX_SCHED_CNT_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  localparam int RunW = (MAX_KEY_RUN < 1) ? 1 : $clog2(MAX_KEY_RUN + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(MAX_KEY_RUN);

  // Entry 8'h00 occupies the top byte.
  localparam logic [2047:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxTbl[{~x, 3'b000} +: 8];
  endfunction

  typedef enum logic {StIdle, StRun} state_e;

  state_e           r_state;
  logic [127:0]     r_buf;
  logic [1:0]       r_beat;
  logic [RunW-1:0]  r_key_run;
  logic [127:0]     r_st_out;
  logic [31:0]      r_kw_out;
  logic             r_st_done;
  logic             r_kw_done;

  logic             w_busy;
  logic             w_key_ok;
  logic             w_kw_grant;
  logic             w_st_grant;
  logic [31:0]      w_col;
  logic [31:0]      w_lane_in;
  logic [31:0]      w_lane_out;

  assign w_busy     = (r_state == StRun);
  assign w_key_ok   = !w_busy || ((PRIO_KEY != 0) && (r_key_run != RunMax));
  assign w_kw_grant = kw_valid && w_key_ok;
  assign w_st_grant = w_busy && !w_kw_grant;
  // Column k lives at [127-32k -: 32]; ~beat == 3-k.
  assign w_col      = r_buf[{~r_beat, 5'b00000} +: 32];
  assign w_lane_in  = w_kw_grant ? kw_in : w_col;
  assign w_lane_out = {sbox(w_lane_in[31:24]), sbox(w_lane_in[23:16]),
                       sbox(w_lane_in[15:8]),  sbox(w_lane_in[7:0])};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_buf     <= '0;
      r_beat    <= '0;
      r_key_run <= '0;
      r_st_out  <= '0;
      r_kw_out  <= '0;
      r_st_done <= 1'b0;
      r_kw_done <= 1'b0;
    end else begin
      r_kw_done <= w_kw_grant;
      r_st_done <= 1'b0;
      if (w_kw_grant) r_kw_out <= w_lane_out;
      case (r_state)
        StIdle: begin
          r_key_run <= '0;
          if (st_valid) begin
            r_buf   <= st_in;
            r_beat  <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (w_st_grant) begin
            r_st_out[{~r_beat, 5'b00000} +: 32] <= w_lane_out;
            r_beat    <= r_beat + 2'd1;
            r_key_run <= '0;
            if (r_beat == 2'd3) begin
              r_state   <= StIdle;
              r_st_done <= 1'b1;
            end
          end else if (w_kw_grant && (r_key_run != RunMax)) begin
            r_key_run <= r_key_run + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef SBOX_SCHED_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_busy && w_kw_grant && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign busy     = w_busy;
  assign st_ready = !w_busy;
  assign kw_ready = w_key_ok;
  assign st_out   = r_st_out;
  assign st_done  = r_st_done;
  assign kw_out   = r_kw_out;
  assign kw_done  = r_kw_done;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed bench: dut0 uses key priority (MAX_KEY_RUN=2), dut1 state priority; shared stimulus.
module tb_sbox_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, st_valid, kw_valid;
  logic [127:0] st_in;
  logic [31:0]  kw_in;

  logic         st_ready0, st_done0, kw_ready0, kw_done0, busy0;
  logic [127:0] st_out0;
  logic [31:0]  kw_out0;
  logic         st_ready1, st_done1, kw_ready1, kw_done1, busy1;
  logic [127:0] st_out1;
  logic [31:0]  kw_out1;
`ifdef SBOX_SCHED_CNT_EN
  logic [15:0]  stall0, stall1;
`endif

  int checks = 0;
  int errors = 0;

  sbox_scheduler #(.PRIO_KEY(1), .MAX_KEY_RUN(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready0), .st_in(st_in),
    .st_out(st_out0), .st_done(st_done0), .kw_valid(kw_valid), .kw_ready(kw_ready0),
    .kw_in(kw_in), .kw_out(kw_out0), .kw_done(kw_done0), .busy(busy0)
`ifdef SBOX_SCHED_CNT_EN
    , .stall_cnt(stall0)
`endif
  );

  sbox_scheduler #(.PRIO_KEY(0), .MAX_KEY_RUN(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready1), .st_in(st_in),
    .st_out(st_out1), .st_done(st_done1), .kw_valid(kw_valid), .kw_ready(kw_ready1),
    .kw_in(kw_in), .kw_out(kw_out1), .kw_done(kw_done1), .busy(busy1)
`ifdef SBOX_SCHED_CNT_EN
    , .stall_cnt(stall1)
`endif
  );

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
  } kvec_t;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } svec_t;

  localparam logic [127:0] FipsIn  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FipsOut = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] All63   = 128'h63636363636363636363636363636363;
  localparam logic [127:0] All16   = 128'h16161616161616161616161616161616;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [127:0] d);
    st_valid = 1'b1;
    st_in    = d;
    tick();
    st_valid = 1'b0;
  endtask

  // Returns the cycle index (acceptance edge = 0) at which each DUT shows st_done; 0 = timeout.
  task automatic wait_done(input int c0, output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int c = c0; c <= 30; c++) begin
      if (st_done0 && n0 == 0) n0 = c;
      if (st_done1 && n1 == 0) n1 = c;
      if (n0 != 0 && n1 != 0) break;
      tick();
    end
  endtask

  kvec_t kv[4];
  svec_t sv[3];
  int n0, n1;
  logic [12:0] kr0, sd0, kr1, sd1;
  logic any_done;

  initial begin
    kv[0] = '{32'h00010203, 32'h637c777b};
    kv[1] = '{32'h19a09ae9, 32'hd4e0b81e};
    kv[2] = '{32'hffffffff, 32'h16161616};
    kv[3] = '{32'h53535353, 32'hedededed};
    sv[0] = '{FipsIn, FipsOut};
    sv[1] = '{{128{1'b1}}, All16};
    sv[2] = '{128'h0, All63};

    rst_n = 1'b0; st_valid = 1'b0; kw_valid = 1'b0; st_in = '0; kw_in = '0;
    tick();
    tick();
    chk("rst_st_out", st_out0, 128'h0);
    chk("rst_kw_out", kw_out0, 128'h0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_st_ready", st_ready0, 1'b1);
    chk("rst_kw_ready", kw_ready0, 1'b1);
    chk("rst_dones", {st_done0, kw_done0, st_done1, kw_done1}, 4'b0000);
    rst_n = 1'b1;
    tick();

    // Idle key words: one-cycle latency, output held afterwards.
    for (int i = 0; i < 4; i++) begin
      kw_valid = 1'b1;
      kw_in    = kv[i].din;
      #1;
      chk("kw_ready_idle", kw_ready0, 1'b1);
      tick();
      kw_valid = 1'b0;
      chk("kw_done", kw_done0, 1'b1);
      chk("kw_out0", kw_out0, kv[i].dout);
      chk("kw_out1", kw_out1, kv[i].dout);
      tick();
      chk("kw_done_pulse", kw_done0, 1'b0);
      chk("kw_out_hold", kw_out0, kv[i].dout);
    end

    // Uncontended state jobs.
    for (int i = 0; i < 3; i++) begin
      start_job(sv[i].din);
      chk("busy_run", busy0, 1'b1);
      chk("st_ready_run", st_ready0, 1'b0);
      wait_done(1, n0, n1);
      chk("st_lat0", n0, 5);
      chk("st_lat1", n1, 5);
      chk("st_out0", st_out0, sv[i].dout);
      chk("st_out1", st_out1, sv[i].dout);
      chk("st_ready_done", st_ready0, 1'b1);
      tick();
      chk("st_done_pulse", st_done0, 1'b0);
    end

    // Key held high through a job: dut0 interleaves K,K,S; dut1 starves the key.
    kw_valid = 1'b1;
    kw_in    = 32'h00010203;
    start_job(FipsIn);
    kr0 = '0; sd0 = '0; kr1 = '0; sd1 = '0;
    for (int c = 1; c <= 13; c++) begin
      kr0[c-1] = kw_ready0;
      sd0[c-1] = st_done0;
      kr1[c-1] = kw_ready1;
      sd1[c-1] = st_done1;
      if (c < 13) tick();
    end
    chk("grant_pat0", kr0, 13'b1011011011011);
    chk("done_pat0", sd0, 13'b1000000000000);
    chk("grant_pat1", kr1, 13'b1111111110000);
    chk("done_pat1", sd1, 13'b0000000010000);
    chk("contend_st_out0", st_out0, FipsOut);
    chk("contend_st_out1", st_out1, FipsOut);
    chk("contend_kw_out0", kw_out0, 32'h637c777b);
`ifdef SBOX_SCHED_CNT_EN
    chk("stall_cnt0", stall0, 16'd8);
    chk("stall_cnt1", stall1, 16'd0);
`endif
    kw_valid = 1'b0;
    tick();

    // Reset after beat 1 abandons the job.
    start_job(FipsIn);
    tick();
    tick();
    chk("partial_upper", st_out0[127:64], 64'hd42711aee0bf98f1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_st_out", st_out0, 128'h0);
    chk("midrst_busy", busy0, 1'b0);
    any_done = st_done0;
    for (int c = 0; c < 6; c++) begin
      tick();
      any_done = any_done | st_done0;
    end
    chk("midrst_no_done", any_done, 1'b0);

    // Reset wins over a simultaneous acceptance.
    rst_n = 1'b0;
    st_valid = 1'b1;
    st_in = {128{1'b1}};
    tick();
    rst_n = 1'b1;
    st_valid = 1'b0;
    chk("rst_over_accept", busy0, 1'b0);
    tick();

    start_job(128'h0);
    wait_done(1, n0, n1);
    chk("post_rst_lat", n0, 5);
    chk("post_rst_out", st_out0, All63);
    tick();

    // Back-to-back jobs, second accepted in the st_done cycle.
    start_job(128'h0);
    wait_done(1, n0, n1);
    chk("b2b_lat_a", n0, 5);
    chk("b2b_ready", st_ready0, 1'b1);
    start_job({128{1'b1}});
    tick();
    chk("b2b_retain", st_out0, {32'h16161616, 96'h636363636363636363636363});
    wait_done(2, n0, n1);
    chk("b2b_lat_b", n0, 5);
    chk("b2b_out", st_out0, All16);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
